// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite fetch engine: FSM states,
// default geometry / colour key, and the buffered pixel record.
package sprite_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int          DEF_SPRITE_W  = 64;
   localparam int          DEF_SPRITE_H  = 64;
   localparam logic [23:0] DEF_KEY_COLOR = 24'hFF00FF;

   typedef struct packed {
      logic [23:0] rgb;
      logic [5:0]  x;
      logic [5:0]  y;
      logic        last;
   } pixel_t;

endpackage

// File: rtl/sprite_fetch_if.sv
// Control, frame RAM and pixel stream signals of the sprite fetch engine.
interface sprite_fetch_if;

   logic        start;
   logic        busy;
   logic [12:0] read_address;
   logic [23:0] data_in;
   // A pixel moves on a rising edge where pix_valid && pix_ready; once
   // pix_valid is high it and the whole payload hold until that edge.
   logic        pix_valid;
   logic        pix_ready;
   logic [23:0] pix_data;
   logic [5:0]  pix_x;
   logic [5:0]  pix_y;
   logic        pix_opaque;
   logic        pix_last;

   modport master (
      input  start, data_in, pix_ready,
      output busy, read_address, pix_valid, pix_data, pix_x, pix_y,
             pix_opaque, pix_last
   );

   modport slave (
      output start, data_in, pix_ready,
      input  busy, read_address, pix_valid, pix_data, pix_x, pix_y,
             pix_opaque, pix_last
   );

endinterface

// File: rtl/sprite_skid_fifo.sv
// Two-entry pixel buffer between the frame RAM return path and the stream.
module sprite_skid_fifo
   import sprite_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  pixel_t     push_data,
   input  logic       pop,
   output pixel_t     head,
   output logic       full,
   output logic       empty,
   output logic [1:0] count
);

   pixel_t slot0;
   pixel_t slot1;
   logic   wr_sel;
   logic   rd_sel;
   logic   push_ok;
   logic   pop_ok;

   assign empty   = (count == 2'd0);
   assign full    = (count == 2'd2);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = rd_sel ? slot1 : slot0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot0  <= '0;
         slot1  <= '0;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            if (wr_sel) slot1 <= push_data;
            else        slot0 <= push_data;
            wr_sel <= ~wr_sel;
         end
         if (pop_ok) rd_sel <= ~rd_sel;
         count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

endmodule

// File: rtl/sprite_fetch.sv
// Raster-scans one sprite out of an external frame RAM (1-cycle read latency)
// and streams it as tagged pixels over a valid/ready interface.
module sprite_fetch
   import sprite_pkg::*;
#(
   parameter int          SPRITE_W  = DEF_SPRITE_W,
   parameter int          SPRITE_H  = DEF_SPRITE_H,
   parameter logic [23:0] KEY_COLOR = DEF_KEY_COLOR
)(
   input  logic           clk,
   input  logic           rst,
   sprite_fetch_if.master bus,
   output state_t         state_dbg
);

   state_t     state;
   logic       busy_q;
   logic [5:0] x_cnt;
   logic [5:0] y_cnt;
   logic       inflight;
   logic [5:0] tag_x;
   logic [5:0] tag_y;
   logic       tag_last;
   logic [11:0] addr;
   logic       at_last_addr;
   logic       issue;
   logic       pop;
   logic       full;
   logic       empty;
   logic [1:0] count;
   pixel_t     push_pix;
   pixel_t     head;

   assign addr         = 12'(y_cnt) * 12'(SPRITE_W) + 12'(x_cnt);
   assign at_last_addr = (x_cnt == 6'(SPRITE_W - 1)) && (y_cnt == 6'(SPRITE_H - 1));
   assign pop          = !empty && bus.pix_ready;
   // The read presented this cycle returns next cycle; only issue it if the
   // buffer is guaranteed a free slot when that data lands.
   assign issue        = (state == FETCH) &&
                         (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
   assign push_pix     = '{rgb: bus.data_in, x: tag_x, y: tag_y, last: tag_last};

   sprite_skid_fifo u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (push_pix),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         busy_q   <= 1'b0;
         x_cnt    <= '0;
         y_cnt    <= '0;
         inflight <= 1'b0;
         tag_x    <= '0;
         tag_y    <= '0;
         tag_last <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            tag_x    <= x_cnt;
            tag_y    <= y_cnt;
            tag_last <= at_last_addr;
            if (x_cnt == 6'(SPRITE_W - 1)) begin
               x_cnt <= '0;
               y_cnt <= at_last_addr ? 6'd0 : y_cnt + 6'd1;
            end else begin
               x_cnt <= x_cnt + 6'd1;
            end
         end
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= FETCH;
                  busy_q <= 1'b1;
               end
            end
            FETCH: begin
               if (issue && at_last_addr) state <= DRAIN;
            end
            DRAIN: begin
               if (pop && head.last) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy         = busy_q;
   assign bus.read_address = {1'b0, addr};
   assign bus.pix_valid    = !empty;
   assign bus.pix_data     = empty ? 24'd0 : head.rgb;
   assign bus.pix_x        = empty ? 6'd0 : head.x;
   assign bus.pix_y        = empty ? 6'd0 : head.y;
   assign bus.pix_opaque   = !empty && (head.rgb != KEY_COLOR);
   assign bus.pix_last     = !empty && head.last;
   assign state_dbg        = state;

   assert property (@(posedge clk) disable iff (rst) !(full && inflight && !pop));

endmodule

// File: tb/tb_sprite_fetch.sv
// Bench for sprite_fetch: RAM model, random back-pressure, and a scan-level
// reference model feeding an expected-pixel queue.
module tb_sprite_fetch;
   import sprite_pkg::*;

   localparam int          NPIX = 4096;
   localparam logic [23:0] KEY  = 24'hFF00FF;

   logic   clk = 1'b0;
   logic   rst;
   state_t state_dbg;

   sprite_fetch_if bus();

   sprite_fetch dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   int          checks     = 0;
   int          errors     = 0;
   int          cyc        = 0;
   int          scan_got   = 0;
   int          scans_done = 0;
   int          first_hs   = 0;
   logic [37:0] exp_q[$];
   logic        key_mode     = 1'b0;
   logic        ready_rand   = 1'b0;
   logic        model_busy   = 1'b0;
   logic        start_edge   = 1'b0;
   logic        hs_last_prev = 1'b0;

   function automatic logic [23:0] ram_word(input logic [12:0] a);
      if (key_mode && a == 13'd5) return KEY;
      return {11'd0, a};
   endfunction

   // Pixel n of a scan: {rgb, x, y, opaque, last}
   function automatic logic [37:0] model_pixel(input int n);
      logic [23:0] rgb;
      logic [5:0]  x;
      logic [5:0]  y;
      x   = 6'(n % 64);
      y   = 6'(n / 64);
      rgb = ram_word(13'(n));
      return {rgb, x, y, rgb != KEY, n == NPIX - 1};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) start_edge <= bus.start;
   always @(posedge clk) bus.data_in <= ram_word(bus.read_address);

   initial begin
      bus.pix_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.pix_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Compare process: scan-level model of busy plus in-order pixel scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            check("rst_busy", 64'(bus.busy), 64'd0);
            check("rst_valid", 64'(bus.pix_valid), 64'd0);
            check("rst_last", 64'(bus.pix_last), 64'd0);
            check("rst_opaque", 64'(bus.pix_opaque), 64'd0);
            check("rst_data", 64'(bus.pix_data), 64'd0);
            check("rst_x", 64'(bus.pix_x), 64'd0);
            check("rst_y", 64'(bus.pix_y), 64'd0);
            check("rst_addr", 64'(bus.read_address), 64'd0);
            exp_q.delete();
            model_busy   = 1'b0;
            hs_last_prev = 1'b0;
            scan_got     = 0;
         end else begin
            if (model_busy) begin
               if (hs_last_prev) model_busy = 1'b0;
            end else if (start_edge) begin
               model_busy = 1'b1;
               scan_got   = 0;
               for (int n = 0; n < NPIX; n++) exp_q.push_back(model_pixel(n));
            end
            check("busy", 64'(bus.busy), 64'(model_busy));
            check("addr_bit12", 64'(bus.read_address[12]), 64'd0);
            if (bus.pix_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pixel x=%0d y=%0d required=none", bus.pix_x, bus.pix_y);
               end else begin
                  check("pixel", 64'({bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_opaque, bus.pix_last}),
                        64'(exp_q[0]));
                  if (bus.pix_ready) begin
                     if (key_mode && bus.pix_x == 6'd5 && bus.pix_y == 6'd0)
                        check("key_opaque_pin", 64'(bus.pix_opaque), 64'd0);
                     if (!key_mode && bus.pix_x == 6'd1 && bus.pix_y == 6'd1)
                        check("data_pin_1_1", 64'(bus.pix_data), 64'd65);
                     scan_got++;
                     if (scan_got == 1) first_hs = cyc;
                     void'(exp_q.pop_front());
                     if (exp_q.size() == 0) begin
                        scans_done++;
                        check("scan_count", 64'(scan_got), 64'(NPIX));
                        if (!ready_rand) check("full_rate_span", 64'(cyc - first_hs), 64'(NPIX - 1));
                     end
                  end
               end
            end
            hs_last_prev = bus.pix_valid && bus.pix_ready && bus.pix_last;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      repeat (2) @(negedge clk);
      while (model_busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("scan_done_in_time", 64'(model_busy), 64'd0);
   endtask

   initial begin
      int  n;
      logic found;
      rst       = 1'b1;
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state", 64'(state_dbg), 64'(IDLE));
      @(posedge clk);
      #3 rst = 1'b0;

      // Scan 1: full rate, first-pixel latency
      ready_rand = 1'b0;
      pulse_start();
      @(negedge clk);
      check("lat_busy_t0", 64'(bus.busy), 64'd1);
      check("lat_state_t0", 64'(state_dbg), 64'(FETCH));
      check("lat_addr_t0", 64'(bus.read_address), 64'd0);
      check("lat_valid_t0", 64'(bus.pix_valid), 64'd0);
      @(negedge clk);
      check("lat_valid_t1", 64'(bus.pix_valid), 64'd0);
      @(negedge clk);
      check("lat_valid_t2", 64'(bus.pix_valid), 64'd1);
      check("lat_xy_t2", 64'({bus.pix_x, bus.pix_y}), 64'd0);
      check("lat_data_t2", 64'(bus.pix_data), 64'd0);
      wait_idle(6000);

      // Scan 2: random back-pressure
      ready_rand = 1'b1;
      pulse_start();
      wait_idle(30000);

      // Scan 3: colour key at word 5
      key_mode = 1'b1;
      pulse_start();
      wait_idle(30000);
      key_mode = 1'b0;

      // Reset part way through a scan, then a clean restart
      pulse_start();
      n = 0;
      while (scan_got < 1000 && n < 10000) begin
         @(negedge clk);
         n++;
      end
      check("reached_pixel_1000", 64'(scan_got >= 1000), 64'd1);
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_state", 64'(state_dbg), 64'(IDLE));
      @(posedge clk);
      #3 rst = 1'b0;
      pulse_start();
      wait_idle(30000);

      // Scan 5: starts while busy and on the final handshake edge
      ready_rand = 1'b0;
      pulse_start();
      repeat (4) begin
         repeat (300) @(posedge clk);
         #1 bus.start = 1'b1;
         @(posedge clk);
         #1 bus.start = 1'b0;
      end
      found = 1'b0;
      n = 0;
      while (!found && n < 6000) begin
         @(negedge clk);
         found = bus.pix_valid && bus.pix_last && bus.pix_ready;
         n++;
      end
      check("final_hs_seen", 64'(found), 64'd1);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (40) @(negedge clk);
      check("after_busy", 64'(bus.busy), 64'd0);
      check("after_state", 64'(state_dbg), 64'(IDLE));
      check("after_queue_empty", 64'(exp_q.size()), 64'd0);
      check("scans_done", 64'(scans_done), 64'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
